// File: rtl/pulse_seq_pkg.sv
// rtl/pulse_seq_pkg.sv - shared types, widths and segment helpers for the pulse sequencer
package pulse_seq_pkg;

    localparam int CW = 16;
    localparam int AW = 12;

    typedef enum logic [2:0] {
        SEG_IDLE  = 3'd0,
        SEG_DELAY = 3'd1,
        SEG_RISE  = 3'd2,
        SEG_HIGH  = 3'd3,
        SEG_FALL  = 3'd4,
        SEG_LOW   = 3'd5
    } seg_e;

    typedef struct packed {
        logic [CW-1:0] td;
        logic [CW-1:0] tr;
        logic [CW-1:0] th;
        logic [CW-1:0] tf;
        logic [CW-1:0] tl;
        logic [AW-1:0] iv;
        logic [AW-1:0] pv;
        logic [AW-1:0] step;
        logic [CW-1:0] cycles;
    } cfg_t;

    function automatic logic [CW-1:0] seg_dur(seg_e s, cfg_t c);
        case (s)
            SEG_DELAY: seg_dur = c.td;
            SEG_RISE:  seg_dur = c.tr;
            SEG_HIGH:  seg_dur = c.th;
            SEG_FALL:  seg_dur = c.tf;
            SEG_LOW:   seg_dur = c.tl;
            default:   seg_dur = '0;
        endcase
    endfunction

    function automatic seg_e seg_after(seg_e s);
        case (s)
            SEG_RISE: seg_after = SEG_HIGH;
            SEG_HIGH: seg_after = SEG_FALL;
            SEG_FALL: seg_after = SEG_LOW;
            default:  seg_after = SEG_RISE;
        endcase
    endfunction

    // First segment with nonzero duration, scanning the period cyclically from start.
    function automatic seg_e first_active(seg_e start, cfg_t c);
        seg_e s;
        s = start;
        first_active = SEG_IDLE;
        for (int i = 0; i < 4; i++) begin
            if (first_active == SEG_IDLE && seg_dur(s, c) != '0)
                first_active = s;
            s = seg_after(s);
        end
    endfunction

    function automatic seg_e last_active(cfg_t c);
        if (c.tl != '0)      last_active = SEG_LOW;
        else if (c.tf != '0) last_active = SEG_FALL;
        else if (c.th != '0) last_active = SEG_HIGH;
        else if (c.tr != '0) last_active = SEG_RISE;
        else                 last_active = SEG_IDLE;
    endfunction

    // One ramp step toward tgt; the extra bit turns overflow/underflow into a clamp.
    function automatic logic [AW-1:0] ramp_step(logic [AW-1:0] cur, logic [AW-1:0] tgt,
                                                logic [AW-1:0] step, logic up);
        logic [AW:0] sum;
        if (up) begin
            sum = {1'b0, cur} + {1'b0, step};
            ramp_step = (sum > {1'b0, tgt}) ? tgt : sum[AW-1:0];
        end else begin
            sum = {1'b0, cur} - {1'b0, step};
            ramp_step = (sum[AW] || sum[AW-1:0] < tgt) ? tgt : sum[AW-1:0];
        end
    endfunction

endpackage

// File: rtl/pulse_seq_if.sv
// rtl/pulse_seq_if.sv - configuration channel between stimulus controller and sequencer
interface pulse_seq_if;
    import pulse_seq_pkg::*;

    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] cfg_td, cfg_tr, cfg_th, cfg_tf, cfg_tl, cfg_cycles;
    logic [AW-1:0] cfg_iv, cfg_pv, cfg_step;

    modport master (
        output cfg_valid, cfg_td, cfg_tr, cfg_th, cfg_tf, cfg_tl, cfg_cycles,
               cfg_iv, cfg_pv, cfg_step,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_td, cfg_tr, cfg_th, cfg_tf, cfg_tl, cfg_cycles,
               cfg_iv, cfg_pv, cfg_step,
        output cfg_ready
    );
endinterface

// File: rtl/pulse_seq_seg_timer.sv
// rtl/pulse_seq_seg_timer.sv - loadable segment down-counter shared by all segments
module pulse_seq_seg_timer
    import pulse_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] dur,
    output logic          last,
    output logic          last_next
);
    logic [CW-1:0] cnt;
    logic          dur_zero;

    // cnt holds the cycles remaining after the current one, so zero marks the last cycle.
    assign dur_zero  = (dur == '0);
    assign last      = (cnt == '0);
    assign last_next = load ? (dur <= CW'(1)) : (cnt <= CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= dur_zero ? '0 : dur - CW'(1);
        else if (!last)
            cnt <= cnt - CW'(1);
    end
endmodule

// File: rtl/pulse_seq.sv
// rtl/pulse_seq.sv - trapezoidal pulse sequencer: segment FSM, ramp accumulator, period counter
module pulse_seq
    import pulse_seq_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    pulse_seq_if.slave    cfg_if,
    input  logic          abort,
    output logic [AW-1:0] level,
    output seg_e          seg,
    output logic          busy,
    output logic          period_tick,
    output logic          done
);
    cfg_t          cfg_q, cfg_in, c_use;
    logic          ready_q, ready_nxt, accept, up, load;
    logic          tmr_last, tmr_last_next, tick_nxt, done_nxt;
    seg_e          seg_nxt;
    logic [AW-1:0] base, level_nxt;
    logic [CW-1:0] pcnt, pcnt_nxt, dur;

    assign cfg_in = '{td: cfg_if.cfg_td, tr: cfg_if.cfg_tr, th: cfg_if.cfg_th,
                      tf: cfg_if.cfg_tf, tl: cfg_if.cfg_tl, iv: cfg_if.cfg_iv,
                      pv: cfg_if.cfg_pv, step: cfg_if.cfg_step, cycles: cfg_if.cfg_cycles};

    assign cfg_if.cfg_ready = ready_q;
    assign accept = ready_q && cfg_if.cfg_valid;
    // On the accepting edge the fresh word drives everything, including the ramp origin.
    assign c_use  = accept ? cfg_in : cfg_q;
    assign base   = accept ? cfg_in.iv : level;
    assign up     = (c_use.pv >= c_use.iv);
    assign dur    = seg_dur(seg_nxt, c_use);

    pulse_seq_seg_timer u_seg_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .dur       (dur),
        .last      (tmr_last),
        .last_next (tmr_last_next)
    );

    always_comb begin
        seg_nxt   = seg;
        load      = 1'b0;
        ready_nxt = ready_q;
        done_nxt  = 1'b0;
        pcnt_nxt  = pcnt;
        if (accept) begin
            load      = 1'b1;
            ready_nxt = 1'b0;
            pcnt_nxt  = '0;
            seg_nxt   = (cfg_in.td != '0) ? SEG_DELAY : first_active(SEG_RISE, cfg_in);
            done_nxt  = (seg_nxt == SEG_IDLE);
        end else if (busy) begin
            if (period_tick)
                pcnt_nxt = pcnt + CW'(1);
            if (abort || done) begin
                seg_nxt   = SEG_IDLE;
                ready_nxt = 1'b1;
            end else if (tmr_last) begin
                load     = 1'b1;
                seg_nxt  = (seg == SEG_DELAY) ? first_active(SEG_RISE, cfg_q)
                                              : first_active(seg_after(seg), cfg_q);
                done_nxt = (seg_nxt == SEG_IDLE);
            end
        end else if (!ready_q) begin
            ready_nxt = 1'b1;
        end

        tick_nxt = (seg_nxt != SEG_IDLE) && (seg_nxt == last_active(c_use)) && tmr_last_next;
        done_nxt = done_nxt || (tick_nxt && c_use.cycles != '0 &&
                                (pcnt_nxt + CW'(1)) == c_use.cycles);

        case (seg_nxt)
            SEG_RISE: level_nxt = ramp_step(base, c_use.pv, c_use.step, up);
            SEG_HIGH: level_nxt = c_use.pv;
            SEG_FALL: level_nxt = ramp_step(base, c_use.iv, c_use.step, !up);
            default:  level_nxt = c_use.iv;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_q       <= '0;
            seg         <= SEG_IDLE;
            level       <= '0;
            busy        <= 1'b0;
            period_tick <= 1'b0;
            done        <= 1'b0;
            ready_q     <= 1'b1;
            pcnt        <= '0;
        end else begin
            if (accept)
                cfg_q <= cfg_in;
            seg         <= seg_nxt;
            level       <= level_nxt;
            busy        <= (seg_nxt != SEG_IDLE);
            period_tick <= tick_nxt;
            done        <= done_nxt;
            ready_q     <= ready_nxt;
            pcnt        <= pcnt_nxt;
        end
    end
endmodule
